// File: rtl/spart_fifo.sv
// SPART-style UART: 8-bit processor bus, TX/RX FIFOs, 16x oversampled serial engine.
// Define SPART_PARITY_EN to add an even parity bit in both directions.
module spart_fifo #(
  parameter int          DATA_BITS  = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'h0144
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

`ifdef SPART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam state_t S_AFTER_DATA = S_STOP;
`endif

  logic [15:0]          div_q, div_d, baud_cnt_q, baud_cnt_d;
  logic                 tick;
  logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PTR_W-1:0]     rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  state_t               tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [3:0]           tx_tcnt_q, tx_tcnt_d, rx_tcnt_q, rx_tcnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [DATA_BITS-1:0] tx_head;
  logic [1:0]           sync_q;
  logic                 rx_prev_q, rx_s, rx_mid, rx_last;
  logic [2:0]           err_q, err_d, err_set, err_clr;  // {parity, frame, overrun}
  logic                 wr, rd, tx_push, tx_pop, rx_push, rx_pop, rx_done;
  logic                 frame_set, par_set, tx_full, rx_empty;
  logic [7:0]           rdata;
`ifdef SPART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  assign wr       = iocs && !iorw;
  assign rd       = iocs && iorw;
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign tbr      = !tx_full;
  assign rda      = !rx_empty;
  assign tx_push  = wr && (ioaddr == 2'b00) && !tx_full;
  assign rx_pop   = rd && (ioaddr == 2'b00) && !rx_empty;
  // A completing character may take the slot freed by a same-cycle pop.
  assign rx_push  = rx_done && (!rx_full_blocked());
  assign tx_head  = tx_mem_q[tx_rptr_q];
  assign rx_s     = sync_q[1];
  assign rx_mid   = (rx_tcnt_q == 4'd7);
  assign rx_last  = (rx_tcnt_q == 4'd15);

  function automatic logic rx_full_blocked();
    return (rx_cnt_q == FULL_CNT) && !rx_pop;
  endfunction

  // Baud tick generator and divisor registers
  always_comb begin
    tick       = (baud_cnt_q == 16'd0);
    baud_cnt_d = tick ? div_q : baud_cnt_q - 16'd1;
    div_d      = div_q;
    if (wr && ioaddr == 2'b10) div_d[7:0]  = databus;
    if (wr && ioaddr == 2'b11) div_d[15:8] = databus;
    if (wr && ioaddr[1])       baud_cnt_d  = div_d;
  end

  // FIFO pointers and occupancy
  always_comb begin
    tx_wptr_d = tx_push ? tx_wptr_q + 1'b1 : tx_wptr_q;
    tx_rptr_d = tx_pop  ? tx_rptr_q + 1'b1 : tx_rptr_q;
    rx_wptr_d = rx_push ? rx_wptr_q + 1'b1 : rx_wptr_q;
    rx_rptr_d = rx_pop  ? rx_rptr_q + 1'b1 : rx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: ;
    endcase
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: ;
    endcase
  end

  // Transmit next-state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
`ifdef SPART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tick) begin
      case (tx_state_q)
        S_IDLE: if (tx_cnt_q != '0) begin
          tx_pop     = 1'b1;
          tx_state_d = S_START;
          tx_tcnt_d  = 4'd0;
        end
        default: begin
          tx_tcnt_d = tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            case (tx_state_q)
              S_START: begin
                tx_state_d = S_DATA;
                tx_bit_d   = 3'd0;
              end
              S_DATA: begin
                tx_shift_d = tx_shift_q >> 1;
                if (tx_bit_q == LAST_BIT) tx_state_d = S_AFTER_DATA;
                else                      tx_bit_d   = tx_bit_q + 3'd1;
              end
`ifdef SPART_PARITY_EN
              S_PARITY: tx_state_d = S_STOP;
`endif
              S_STOP: begin
                // Back-to-back frames: no idle gap when more data is queued.
                if (tx_cnt_q != '0) begin
                  tx_pop     = 1'b1;
                  tx_state_d = S_START;
                end else begin
                  tx_state_d = S_IDLE;
                end
              end
              default: tx_state_d = S_IDLE;
            endcase
          end
        end
      endcase
    end
    if (tx_pop) begin
      tx_shift_d = tx_head;
`ifdef SPART_PARITY_EN
      tx_par_d   = ^tx_head;
`endif
    end
  end

  // Transmit output decode
  always_comb begin
    case (tx_state_q)
      S_START:  txd = 1'b0;
      S_DATA:   txd = tx_shift_q[0];
`ifdef SPART_PARITY_EN
      S_PARITY: txd = tx_par_q;
`endif
      default:  txd = 1'b1;
    endcase
  end

  // Receive next-state; every bit is sampled at tick 8 of its period
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    frame_set  = 1'b0;
    par_set    = 1'b0;
    case (rx_state_q)
      S_IDLE: if (rx_prev_q && !rx_s) begin
        rx_state_d = S_START;
        rx_tcnt_d  = 4'd0;
      end
      default: if (tick) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        case (rx_state_q)
          S_START: begin
            if (rx_mid && rx_s) rx_state_d = S_IDLE;
            else if (rx_last) begin
              rx_state_d = S_DATA;
              rx_bit_d   = 3'd0;
            end
          end
          S_DATA: begin
            if (rx_mid) rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
            if (rx_last) begin
              if (rx_bit_q == LAST_BIT) rx_state_d = S_AFTER_DATA;
              else                      rx_bit_d   = rx_bit_q + 3'd1;
            end
          end
`ifdef SPART_PARITY_EN
          S_PARITY: begin
            if (rx_mid)  par_set    = (rx_s != ^rx_shift_q);
            if (rx_last) rx_state_d = S_STOP;
          end
`endif
          S_STOP: if (rx_mid) begin
            rx_state_d = S_IDLE;
            rx_done    = rx_s;
            frame_set  = !rx_s;
          end
          default: rx_state_d = S_IDLE;
        endcase
      end
    endcase
  end

  // Sticky errors: a hardware set wins over a same-cycle software clear
  always_comb begin
    err_set = {par_set, frame_set, rx_done && rx_full_blocked()};
    err_clr = (wr && ioaddr == 2'b01) ? databus[4:2] : 3'b000;
    err_d   = (err_q & ~err_clr) | err_set;
  end

  // Processor read mux
  always_comb begin
    rdata = 8'h00;
    case (ioaddr)
      2'b00:   if (!rx_empty) rdata[DATA_BITS-1:0] = rx_mem_q[rx_rptr_q];
      2'b01:   rdata = {3'b000, err_q, tx_full, rx_empty};
      2'b10:   rdata = div_q[7:0];
      default: rdata = div_q[15:8];
    endcase
  end

  assign databus = rd ? rdata : 8'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= DIV_RESET;
      baud_cnt_q <= DIV_RESET;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tx_state_q <= S_IDLE;
      rx_state_q <= S_IDLE;
      tx_tcnt_q  <= 4'd0;
      rx_tcnt_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      rx_bit_q   <= 3'd0;
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      err_q      <= 3'b000;
    end else begin
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      rx_tcnt_q  <= rx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      rx_bit_q   <= rx_bit_d;
      sync_q     <= {sync_q[0], rxd};
      rx_prev_q  <= rx_s;
      err_q      <= err_d;
    end
  end

  // Data storage carries no reset; validity is tracked by the counts above
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= databus[DATA_BITS-1:0];
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_shift_q;
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
`ifdef SPART_PARITY_EN
    tx_par_q   <= tx_par_d;
`endif
  end
endmodule

// File: tb/tb_spart_fifo.sv
// Scoreboarded bench for spart_fifo: bus reads and serial TX frames are checked by monitors.
module tb_spart_fifo;
  localparam int DEPTH = 4;
`ifdef SPART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = 10 + PAR_BITS;
  localparam int FRAME_CLKS = FRAME_BITS * 16;

  logic       clk = 1'b0, rst = 1'b1, iocs = 1'b0, iorw = 1'b1;
  logic       rxd_drv = 1'b1, loop_en = 1'b0, drv_en = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] drv_d = 8'h00;
  wire  [7:0] databus;
  wire        rxd;
  logic       rda, tbr, txd;

  assign databus = drv_en ? drv_d : 8'hzz;
  assign rxd     = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0, n_fail = 0;
  logic [7:0] rd_exp_q[$];
  string      rd_name_q[$];
  logic [7:0] tx_exp_q[$];
  int         start_q[$];
  logic [7:0] rx_m[$];
  logic       ovr_m = 1'b0, frm_m = 1'b0;
  int         tx_cnt_m = 0;

  spart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'h0144)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [FRAME_BITS-1:0] exp_frame(input logic [7:0] d);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[8:1] = d;
`ifdef SPART_PARITY_EN
    f[9] = ^d;
`endif
    f[FRAME_BITS-1] = 1'b1;
    return f;
  endfunction

  function automatic logic [7:0] exp_status(input logic tx_full);
    return {3'b000, 1'b0, frm_m, ovr_m, tx_full, (rx_m.size() == 0)};
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_d = d; drv_en = 1'b1;
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b1; drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string name);
    @(posedge clk); #1;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    @(posedge clk); #1;
    iocs = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    logic [FRAME_BITS-1:0] f;
    f = exp_frame(d);
    f[FRAME_BITS-1] = stop;
    for (int i = 0; i < FRAME_BITS; i++) begin
      rxd_drv = f[i];
      repeat (16) @(posedge clk);
    end
    rxd_drv = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    if (!stop) frm_m = 1'b1;
    else if (rx_m.size() < DEPTH) rx_m.push_back(d);
    else ovr_m = 1'b1;
  endtask

  task automatic wait_rda(input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (rda) ok = 1'b1;
    end
  endtask

  // Bus read monitor
  always @(negedge clk) begin
    if (!rst && iocs && iorw) begin
      if (rd_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%0h with no expected read", databus);
      end else begin
        check(rd_name_q.pop_front(), int'(databus), int'(rd_exp_q.pop_front()));
      end
    end
  end

  // Serial TX monitor: every bit must hold for exactly 16 clocks
  initial begin : tx_mon
    logic [FRAME_BITS-1:0] frame;
    logic                  bad, aborted, first;
    logic [7:0]            e;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        start_q.push_back(cyc);
        frame = '0; bad = 1'b0; aborted = 1'b0; first = 1'b0;
        for (int bi = 0; bi < FRAME_BITS; bi++) begin
          for (int s = 0; s < 16; s++) begin
            if (bi != 0 || s != 0) @(negedge clk);
            if (rst) aborted = 1'b1;
            if (s == 0) first = txd;
            else if (txd !== first) bad = 1'b1;
            if (s == 8) frame[bi] = txd;
          end
        end
        if (!aborted) begin
          if (tx_exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected: frame 0x%0h with no expected byte", frame);
          end else begin
            e = tx_exp_q.pop_front();
            check("tx_frame", int'(frame), int'(exp_frame(e)));
            check("tx_bit_timing", int'(bad), 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] byt;
    logic       ok;
    repeat (3) @(posedge clk); #1;
    check("rst_txd", int'(txd), 1);
    check("rst_tbr", int'(tbr), 1);
    check("rst_rda", int'(rda), 0);
    rst = 1'b0;
    bus_read(2'b01, 8'h01, "rst_status");
    bus_read(2'b10, 8'h44, "rst_div_lo");
    bus_read(2'b11, 8'h01, "rst_div_hi");

    // Divisor read/write, then run at div=0
    bus_write(2'b10, 8'h5A);
    bus_read(2'b10, 8'h5A, "div_lo_rw");
    bus_write(2'b10, 8'h00);
    bus_write(2'b11, 8'h00);
    bus_read(2'b11, 8'h00, "div_hi_rw");

    // Single transmit of A5, then a few random bytes
    bus_write(2'b00, 8'hA5);
    tx_exp_q.push_back(8'hA5);
    repeat (FRAME_CLKS + 40) @(posedge clk); #1;
    check("tx_a5_sent", tx_exp_q.size(), 0);
    check("tx_idle_high", int'(txd), 1);
    for (int i = 0; i < 3; i++) begin
      byt = 8'($urandom);
      bus_write(2'b00, byt);
      tx_exp_q.push_back(byt);
      repeat (FRAME_CLKS + 40) @(posedge clk);
    end

    // Loopback
    loop_en = 1'b1;
    bus_write(2'b00, 8'h3C);
    tx_exp_q.push_back(8'h3C);
    rx_m.push_back(8'h3C);
    wait_rda(FRAME_CLKS + 100, ok);
    check("lb_rda_rise", int'(ok), 1);
    bus_read(2'b00, rx_m.pop_front(), "lb_data");
    check("lb_rda_fall", int'(rda), 0);
    repeat (60) @(posedge clk);
    loop_en = 1'b0;

    // Overrun: five characters into a four-entry FIFO
    for (int i = 0; i < 5; i++) send_rx(8'($urandom), 1'b1);
    bus_read(2'b01, exp_status(1'b0), "ovr_status");
    for (int i = 0; i < DEPTH; i++) bus_read(2'b00, rx_m.pop_front(), "ovr_data");
    bus_read(2'b01, exp_status(1'b0), "ovr_empty_status");
    bus_write(2'b01, 8'h04);
    ovr_m = 1'b0;
    bus_read(2'b01, exp_status(1'b0), "ovr_clear");

    // Pop when empty
    bus_read(2'b00, 8'h00, "empty_pop");
    bus_read(2'b01, exp_status(1'b0), "empty_pop_status");

    // False start, then a good character proves the receiver returned to idle
    @(posedge clk); #1;
    rxd_drv = 1'b0;
    repeat (6) @(posedge clk); #1;
    rxd_drv = 1'b1;
    repeat (40) @(posedge clk); #1;
    check("false_start_rda", int'(rda), 0);
    bus_read(2'b01, exp_status(1'b0), "false_start_status");
    send_rx(8'($urandom), 1'b1);
    check("after_false_rda", int'(rda), 1);
    bus_read(2'b00, rx_m.pop_front(), "after_false_data");

    // Framing error
    send_rx(8'($urandom), 1'b0);
    check("frm_rda", int'(rda), 0);
    bus_read(2'b01, exp_status(1'b0), "frm_status");
    bus_write(2'b01, 8'h08);
    frm_m = 1'b0;
    bus_read(2'b01, exp_status(1'b0), "frm_clear");

    // Fill TX with ticks stalled, then release at div=0
    bus_write(2'b11, 8'h10);
    tx_cnt_m = 0;
    for (int i = 0; i < 5; i++) begin
      byt = 8'($urandom);
      bus_write(2'b00, byt);
      if (tx_cnt_m < DEPTH) begin
        tx_exp_q.push_back(byt);
        tx_cnt_m++;
      end
      check("fill_tbr", int'(tbr), int'(tx_cnt_m < DEPTH));
    end
    bus_read(2'b01, exp_status(1'b1), "full_status");
    start_q.delete();
    bus_write(2'b11, 8'h00);
    repeat (DEPTH * FRAME_CLKS + 80) @(posedge clk); #1;
    check("b2b_frames", start_q.size(), DEPTH);
    for (int i = 1; i < start_q.size(); i++)
      check("b2b_gap", start_q[i] - start_q[i-1], FRAME_CLKS);
    check("b2b_drained", tx_exp_q.size(), 0);
    check("b2b_tbr", int'(tbr), 1);

    // Reset in the middle of a frame
    bus_write(2'b00, 8'($urandom));
    repeat (50) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_txd", int'(txd), 1);
    check("midrst_tbr", int'(tbr), 1);
    check("midrst_rda", int'(rda), 0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    bus_read(2'b01, 8'h01, "midrst_status");
    bus_read(2'b10, 8'h44, "midrst_div_lo");
    repeat (20) @(posedge clk); #1;
    check("midrst_txd_idle", int'(txd), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spart_fifo.md
SPART_FIFO -- requirements
Module: spart_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning serial character length, legal 5..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning entries in each of the TX and RX FIFOs, power of 2, legal 2..16.
REQ-003 SHALL have parameter DIV_RESET, default 16'h0144, meaning divisor value loaded at reset.
REQ-004 SHALL have clk input 1, system clock; all logic on posedge clk.
REQ-005 SHALL have rst input 1, reset, asynchronous, active-high.
REQ-006 SHALL have iocs input 1, chip select, active-high.
REQ-007 SHALL have iorw input 1, 1 = processor read, 0 = processor write.
REQ-008 SHALL have ioaddr input 2, register select.
REQ-009 SHALL have databus inout 8, bidirectional processor data.
REQ-010 SHALL have rda output 1, high while the RX FIFO is non-empty.
REQ-011 SHALL have tbr output 1, high while the TX FIFO is not full.
REQ-012 SHALL have txd output 1, serial transmit, idle high.
REQ-013 SHALL have rxd input 1, serial receive, asynchronous to clk.

Function
REQ-014 Register map (iocs=1): 00 read pops RX head, write pushes TX FIFO; 01 read status, write of 1s clears matching error bits; 10 divisor low byte; 11 divisor high byte; 10/11 readable.
REQ-015 Status byte SHALL be {3'b0, parity_err, frame_err, overrun, tx_full, rx_empty} in bits [7:0].
REQ-016 databus SHALL be driven only when iocs=1 and iorw=1, else high-Z; read data combinational from current state; unused upper bits read 0.
REQ-017 Access side effects (push, pop, clear, divisor write) SHALL occur once per cycle at the posedge where iocs=1.
REQ-018 16x tick: 16-bit down-counter reloaded with divisor on reaching 0, tick pulses one clk at reload; baud = clk/((div+1)*16).
REQ-019 Any divisor byte write SHALL update that byte and reload the counter with the new 16-bit value on the same edge.
REQ-020 TX FSM states IDLE, START, DATA, PARITY (macro only), STOP; each bit lasts 16 ticks; data LSB first, DATA_BITS bits.
REQ-021 TX SHALL leave IDLE at the first tick with the FIFO non-empty, popping the head; after STOP it restarts without idle gap if FIFO non-empty.
REQ-022 TX write while full SHALL be ignored; FIFO contents unchanged.
REQ-023 rxd SHALL pass a 2-flop synchronizer before use.
REQ-024 RX FSM states IDLE, START, DATA, PARITY (macro only), STOP; falling edge in IDLE enters START; start resampled at tick 8; if high, return to IDLE (false start).
REQ-025 RX SHALL sample each data, parity and stop bit at tick 8 of its bit period.
REQ-026 Stop bit low SHALL set frame_err and discard the character; FSM returns to IDLE, waiting for rxd high before a new start.
REQ-027 Character complete with RX FIFO full and no pop that cycle SHALL set overrun and drop the new character; same-cycle pop allows the push.
REQ-028 RX pop when empty SHALL return 0 and not change pointers.
REQ-029 Error bits SHALL be sticky; a hardware set and software clear in the same cycle resolves to set.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty from a count of width clog2(FIFO_DEPTH)+1.

Reset
REQ-031 On rst: txd=1, rda=0, tbr=1, databus high-Z, both FIFOs empty, status 0, divisor=DIV_RESET, counter=DIV_RESET, both FSMs IDLE, synchronizer flops 1.
REQ-032 rst mid-character SHALL abort the frame immediately; txd high on assertion.

Configuration
REQ-033 With SPART_PARITY_EN defined: even parity bit after data on TX; RX checks it, mismatch sets parity_err, character still pushed.
REQ-034 Without SPART_PARITY_EN: no parity bit in either direction, PARITY states absent, parity_err reads 0.

Verification
REQ-035 Reset then read 01, 10, 11 -> 8'h01 (rx_empty), 8'h44, 8'h01; txd=1, tbr=1, rda=0.
REQ-036 div=0, write 8'hA5 to 00 -> txd low 16 clk, then 1,0,1,0,0,1,0,1 each 16 clk, then high 16 clk.
REQ-037 div=0, loop txd to rxd, send 8'h3C -> rda rises after stop sample; read 00 = 8'h3C; rda falls.
REQ-038 FIFO_DEPTH=4, receive 5 characters without reading -> overrun=1, reads return first 4 in order, then rx_empty=1; write 8'h04 to 01 clears overrun.
REQ-039 Drive rxd low 6 ticks then high -> no character, FSM IDLE; send frame with stop bit 0 -> frame_err=1, rda stays 0.
REQ-040 Write 5 bytes to TX with div=0 -> tbr low after 4th held, 5th ignored; exactly 4 back-to-back frames on txd.
